fifo_umbrales: RTL

- Synchronous FIFO with threshold flags; the downstream consumer of the flow-control FSM's threshold outputs.
- Receives the FSM's umbral_L_out/umbral_H_out as its own umbral_L/umbral_H inputs and produces the empty flag fed back to one FSM empty_fifo_N input.
- Eight instances, one per empty_fifo_0..7, close the FSM loop.
- Asserts pause/almost flags so the upstream writer and downstream reader throttle.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_umbrales_if.sv | 35 +++
 rtl/mem_fifo.sv | 37 +++
 rtl/fifo_umbrales.sv | 83 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the threshold FIFO and the flow-control FSM that drives it.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH   = 10;
    localparam int DEF_ADDR_WIDTH   = 3;
    localparam int DEF_UMBRALES_L_H = 8;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so a completely full FIFO is distinguishable from an empty one.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEF_DEPTH = depth_of(DEF_ADDR_WIDTH);

endpackage

// File: rtl/fifo_umbrales_if.sv
// Handshake, threshold and status bundle between a threshold FIFO and its producer/consumer.
interface fifo_umbrales_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int UMBRALES_L_H = DEF_UMBRALES_L_H
);

    logic                    push;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    pop;
    logic [UMBRALES_L_H-1:0] umbral_L;
    logic [UMBRALES_L_H-1:0] umbral_H;

    logic [DATA_WIDTH-1:0]   data_out;
    logic                    valid_out;
    logic                    empty;
    logic                    full;
    logic                    almost_empty;
    logic                    almost_full;
    logic [ADDR_WIDTH:0]     count;
    logic                    error;

    modport master (
        output push, data_in, pop, umbral_L, umbral_H,
        input  data_out, valid_out, empty, full, almost_empty, almost_full, count, error
    );

    modport slave (
        input  push, data_in, pop, umbral_L, umbral_H,
        output data_out, valid_out, empty, full, almost_empty, almost_full, count, error
    );

endinterface

// File: rtl/mem_fifo.sv
// Storage array for the threshold FIFO: one write port, one registered read port.
module mem_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM/flops; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with almost-empty/almost-full threshold flags and a sticky misuse flag.
module fifo_umbrales
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int UMBRALES_L_H = DEF_UMBRALES_L_H
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbrales_if.slave bus
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  valid_q;
    logic                  error_q;
    logic                  is_empty;
    logic                  is_full;
    logic                  push_ok;
    logic                  pop_ok;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    // A full FIFO takes a push only when a pop frees a slot on the same edge; an empty one never bypasses.
    assign pop_ok   = bus.pop && !is_empty;
    assign push_ok  = bus.push && (!is_full || pop_ok);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            valid_q <= pop_ok;
            if ((bus.push && !bus.pop && is_full) || (bus.pop && is_empty)) begin
                error_q <= 1'b1;
            end
        end
    end

    mem_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (bus.data_out)
    );

    // Thresholds are compared live, so a threshold change shows up without waiting for a clock.
    assign bus.valid_out    = valid_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.count        = count_q;
    assign bus.error        = error_q;
    assign bus.almost_empty = (UMBRALES_L_H'(count_q) <= bus.umbral_L);
    assign bus.almost_full  = (UMBRALES_L_H'(count_q) >= bus.umbral_H);

endmodule
